// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port access controller in front of the single-ported 256-byte data
//   memory used by the MEM stage. Port 0 is the pipeline MEM stage, port 1 a
//   secondary master (debug/DMA loader). Each access runs IDLE -> BUSY
//   (WAIT_CYCLES+1 cycles) -> DONE, with a one-cycle done pulse in DONE.
//
//   Request handshake: a requester raises req_n with we_n/addr_n/wdata_n
//   valid and holds req_n high until it sees done_n. The command is latched
//   when the arbiter leaves IDLE; inputs are ignored outside IDLE. A req_n
//   still high in the IDLE cycle after its done pulse is a new request.
//   stall_n = req_n & ~done_n lets the pipeline freeze until the done cycle.
//
//   Optional feature (macro MEM_ARB_ROUND_ROBIN_EN):
//     defined     - round-robin under contention (port 0 first after reset)
//     not defined - fixed priority, port 0 always wins contention
//
//   Parameter: WAIT_CYCLES (0..15) extra BUSY cycles per access.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     req0/1, we0/1            request and write-enable per port
//     addr0/1, wdata0/1        byte address and write data per port
//     done0/1, stall0/1        completion pulse and combinational stall
//     rdata                    data of the last completed read
//     busy                     high in BUSY and DONE
//     mem_read, mem_write      memory strobes
//     mem_address, mem_data    memory address and write data
//     mem_result               combinational memory read data
//     dbg                      {last_grant, gnt, state[1:0]} for observation
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic        stall0,
    output logic        stall1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_result,
    output logic [3:0]  dbg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic        r_gnt;
    logic        r_we_l;
    logic [31:0] r_addr_l;
    logic [31:0] r_wdata_l;
    logic [31:0] r_rdata;
    logic        r_done0;
    logic        r_done1;
    logic        r_busy;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_any_req;
    logic        w_gnt;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    // Grant selection, only consumed in IDLE.
    always_comb begin
        w_any_req = req0 | req1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            w_gnt = ~r_last_grant;
        end else begin
            w_gnt = ~req0;
        end
`else
        w_gnt = ~req0;
`endif
        w_sel_we    = w_gnt ? we1    : we0;
        w_sel_addr  = w_gnt ? addr1  : addr0;
        w_sel_wdata = w_gnt ? wdata1 : wdata0;
    end

    // Strobes are computed one cycle ahead so they are registered: mem_write
    // is raised for the BUSY cycle in which cnt will be zero, giving exactly
    // one write edge per write access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_we_l       <= 1'b0;
            r_addr_l     <= 32'd0;
            r_wdata_l    <= 32'd0;
            r_rdata      <= 32'd0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_we_l       <= w_sel_we;
                        r_addr_l     <= w_sel_addr;
                        r_wdata_l    <= w_sel_wdata;
                        r_cnt        <= C_WAIT;
                        r_busy       <= 1'b1;
                        r_mem_read   <= ~w_sel_we;
                        r_mem_write  <= w_sel_we & (C_WAIT == 4'd0);
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt       <= r_cnt - 4'd1;
                        r_mem_write <= r_we_l & (r_cnt == 4'd1);
                    end else begin
                        if (!r_we_l) begin
                            r_rdata <= mem_result;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_done0     <= ~r_gnt;
                        r_done1     <= r_gnt;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address and data registers only change on entry to BUSY, so they
    // naturally hold their last values in IDLE and DONE.
    assign mem_address = r_addr_l;
    assign mem_data    = r_wdata_l;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign rdata       = r_rdata;
    assign busy        = r_busy;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign stall0      = req0 & ~r_done0;
    assign stall1      = req1 & ~r_done1;
    assign dbg         = {r_last_grant, r_gnt, r_state};

endmodule
